// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Bimodal branch predictor (table of 2-bit saturating counters) plus the
// execute-stage branch/jump resolution logic that picks the next-PC source
// and requests a pipeline flush.
//
// Parameters
//   PC_W      : PC width in bits
//   BHT_DEPTH : number of 2-bit counters (power of two, 2..256)
//   CNT_INIT  : counter value loaded while reset is asserted
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous, active-low reset
//   pcf     in   fetch-stage PC (lookup address)
//   predf   out  fetch prediction, 1 = taken
//   pce     in   execute-stage PC (update address)
//   valide  in   execute slot holds a real instruction (0 = bubble)
//   zero    in   ALU flag: operands equal
//   neg     in   ALU flag: signed less-than
//   ltu     in   ALU flag: unsigned less-than
//   jumpe   in   00 none, 01 jalr, 10 jal, 11 reserved (treated as none)
//   branche in   000 none, 001 beq, 010 bne, 011 blt, 100 bge,
//                101 bltu, 110 bgeu, 111 reserved (treated as none)
//   prede   in   prediction made in fetch for the execute-stage instruction
//   pcsrce  out  00 sequential/predicted, 01 branch/jal target,
//                10 jalr target, 11 pce+4 recovery
//   flushe  out  flush the D and E pipeline registers
//
// Optional feature (macro BPU_STATS_EN):
//   brcnt   out  [31:0] saturating count of resolved valid branches
//   mispcnt out  [31:0] saturating count of mispredicted branches
// ---------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int         PC_W      = 32,
  parameter int         BHT_DEPTH = 16,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pcf,
  output logic            predf,
  input  logic [PC_W-1:0] pce,
  input  logic            valide,
  input  logic            zero,
  input  logic            neg,
  input  logic            ltu,
  input  logic [1:0]      jumpe,
  input  logic [2:0]      branche,
  input  logic            prede,
  output logic [1:0]      pcsrce,
  output logic            flushe
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     brcnt,
  output logic [31:0]     mispcnt
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  // One saturating step of a 2-bit counter towards taken (up=1) or not-taken.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up) begin
      if (cnt != 2'b11) res = cnt + 2'b01;
      else              res = cnt;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'b01;
      else              res = cnt;
    end
    return res;
  endfunction

  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];
  logic             taken;
  logic             is_branch;
  logic             bht_upd;
  logic             mispred;

  // Instructions are word aligned, so the two LSBs carry no index information.
  assign idx_f = pcf[IDX_W+1:2];
  assign idx_e = pce[IDX_W+1:2];

  // PC bits outside the index field are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pcf[PC_W-1:IDX_W+2], pcf[1:0], pce[PC_W-1:IDX_W+2], pce[1:0]};

  // Fetch lookup: reads the registered table, so a same-edge update is not
  // bypassed; during reset the table is being loaded with CNT_INIT.
  always_comb begin
    if (!rst) predf = CNT_INIT[1];
    else      predf = bht_q[idx_f][1];
  end

  // Branch condition evaluation from the ALU flags.
  always_comb begin
    taken = 1'b0;
    case (branche)
      3'b001:  taken = zero;
      3'b010:  taken = ~zero;
      3'b011:  taken = neg;
      3'b100:  taken = ~neg;
      3'b101:  taken = ltu;
      3'b110:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  // Execute-stage resolution: jumps take priority over any branch encoding.
  always_comb begin
    pcsrce    = 2'b00;
    flushe    = 1'b0;
    is_branch = 1'b0;
    mispred   = 1'b0;
    if (valide) begin
      case (jumpe)
        2'b01: begin
          pcsrce = 2'b10;
          flushe = 1'b1;
        end
        2'b10: begin
          pcsrce = 2'b01;
          flushe = 1'b1;
        end
        default: begin
          if ((branche != 3'b000) && (branche != 3'b111)) begin
            is_branch = 1'b1;
            if (taken && !prede) begin
              pcsrce  = 2'b01;
              flushe  = 1'b1;
              mispred = 1'b1;
            end else if (!taken && prede) begin
              pcsrce  = 2'b11;
              flushe  = 1'b1;
              mispred = 1'b1;
            end else begin
              pcsrce  = 2'b00;
              flushe  = 1'b0;
            end
          end else begin
            is_branch = 1'b0;
          end
        end
      endcase
    end else begin
      pcsrce = 2'b00;
      flushe = 1'b0;
    end
  end

  assign bht_upd = is_branch;

  // Next-state of the counter table: only the resolving branch's entry moves.
  always_comb begin
    bht_d = bht_q;
    if (bht_upd) bht_d[idx_e] = sat_step(bht_q[idx_e], taken);
    else         bht_d[idx_e] = bht_q[idx_e];
  end

  // Counter table register; reset overrides any concurrent update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CNT_INIT;
    end else begin
      bht_q <= bht_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] brcnt_q;
  logic [31:0] brcnt_d;
  logic [31:0] mispcnt_q;
  logic [31:0] mispcnt_d;

  // Saturating statistics counters.
  always_comb begin
    brcnt_d   = brcnt_q;
    mispcnt_d = mispcnt_q;
    if (is_branch && (brcnt_q != 32'hFFFF_FFFF)) brcnt_d = brcnt_q + 32'd1;
    else                                         brcnt_d = brcnt_q;
    if (mispred && (mispcnt_q != 32'hFFFF_FFFF)) mispcnt_d = mispcnt_q + 32'd1;
    else                                         mispcnt_d = mispcnt_q;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      brcnt_q   <= 32'd0;
      mispcnt_q <= 32'd0;
    end else begin
      brcnt_q   <= brcnt_d;
      mispcnt_q <= mispcnt_d;
    end
  end

  assign brcnt   = brcnt_q;
  assign mispcnt = mispcnt_q;
`endif

endmodule
